// File: rtl/quantize_stage.sv
// Rounding right-shift and saturation of one accumulator row per cycle, emitting
// exactly ARRAY_SIZE tagged rows per run followed by a one-cycle done pulse.
module quantize_stage #(
    parameter int ARRAY_SIZE        = 8,
    parameter int ACC_WIDTH         = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int SHIFT_WIDTH       = 5
) (
    input  logic                                  clk,
    input  logic                                  srst,
    input  logic                                  start,
    input  logic [SHIFT_WIDTH-1:0]                shift_amt,
    input  logic                                  acc_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]       acc_data,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
    output logic                                  quant_valid,
    output logic [5:0]                            quant_row,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  sat_flag
);

    localparam int EW = ACC_WIDTH + 1;
    localparam int OW = OUTPUT_DATA_WIDTH;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OW - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX - EW'(1);
    localparam logic [5:0] LAST_ROW = 6'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic signed [EW-1:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [SHIFT_WIDTH-1:0]      sh
    );
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] rnd;
        ext = {a[ACC_WIDTH-1], a};
        rnd = '0;
        if (sh != '0) rnd = EW'(1) << (sh - SHIFT_WIDTH'(1));
        // One guard bit keeps the rounding add from overflowing
        return (ext + rnd) >>> sh;
    endfunction

    function automatic logic is_clamped(input logic signed [EW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [OW-1:0] saturate(input logic signed [EW-1:0] x);
        logic signed [EW-1:0] c;
        c = x;
        if (x > SAT_MAX) c = SAT_MAX;
        else if (x < SAT_MIN) c = SAT_MIN;
        return c[OW-1:0];
    endfunction

    state_t                       state_q, state_d;
    logic [5:0]                   row_cnt_q, row_cnt_d;
    logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
    logic                         sat_flag_q, sat_flag_d;
    logic                         vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [5:0]                   row_p1_q, row_p1_d, row_p2_q, row_p2_d;
    logic [ARRAY_SIZE*EW-1:0]     acc_p1_q, acc_p1_d;
    logic [ARRAY_SIZE*OW-1:0]     q_p2_q, q_p2_d;
    logic                         any_clamp;
    logic                         accept;

    assign accept = (state_q == RUN) && acc_valid;

    // Stage 1 -> stage 2 datapath
    always_comb begin
        acc_p1_d  = '0;
        q_p2_d    = '0;
        any_clamp = 1'b0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            acc_p1_d[i*EW +: EW] = round_shift(acc_data[i*ACC_WIDTH +: ACC_WIDTH], shift_q);
            q_p2_d[i*OW +: OW]   = saturate(acc_p1_q[i*EW +: EW]);
            any_clamp            = any_clamp | is_clamped(acc_p1_q[i*EW +: EW]);
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        shift_d    = shift_q;
        sat_flag_d = sat_flag_q | (vld_p1_q & any_clamp);
        vld_p1_d   = accept;
        row_p1_d   = row_cnt_q;
        vld_p2_d   = vld_p1_q;
        row_p2_d   = row_p1_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    shift_d    = shift_amt;
                    sat_flag_d = 1'b0;
                    row_cnt_d  = '0;
                end
            end
            RUN: begin
                if (acc_valid) begin
                    if (row_cnt_q == LAST_ROW) state_d = DRAIN;
                    else row_cnt_d = row_cnt_q + 6'd1;
                end
            end
            DRAIN: begin
                if (vld_p2_q && (row_p2_q == LAST_ROW)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            shift_q    <= '0;
            sat_flag_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            row_p1_q   <= '0;
            row_p2_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            shift_q    <= shift_d;
            sat_flag_q <= sat_flag_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            row_p1_q   <= row_p1_d;
            row_p2_q   <= row_p2_d;
        end
    end

    // Data registers carry no reset; outputs are gated by the stage-2 valid
    always_ff @(posedge clk) begin
        acc_p1_q <= acc_p1_d;
        q_p2_q   <= q_p2_d;
    end

    assign quantized_data = vld_p2_q ? q_p2_q : '0;
    assign quant_row      = vld_p2_q ? row_p2_q : 6'd0;
    assign quant_valid    = vld_p2_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign sat_flag       = sat_flag_q;

endmodule

// File: tb/tb_quantize_stage.sv
// Randomized bench for quantize_stage with a cycle-accurate expected-output queue.
module tb_quantize_stage;

    localparam int N   = 8;
    localparam int AW  = 32;
    localparam int OW  = 16;
    localparam int SW  = 5;
    localparam int BIG = 1 << 30;

    logic               clk = 1'b0;
    logic               srst;
    logic               start;
    logic [SW-1:0]      shift_amt;
    logic               acc_valid;
    logic [N*AW-1:0]    acc_data;
    logic [N*OW-1:0]    quantized_data;
    logic               quant_valid;
    logic [5:0]         quant_row;
    logic               busy;
    logic               done;
    logic               sat_flag;

    quantize_stage #(
        .ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUTPUT_DATA_WIDTH(OW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .srst(srst), .start(start), .shift_amt(shift_amt),
        .acc_valid(acc_valid), .acc_data(acc_data),
        .quantized_data(quantized_data), .quant_valid(quant_valid),
        .quant_row(quant_row), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           row;
        logic [127:0] data;
        bit           sat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_from = BIG;
    int   done_cyc = BIG;
    bit   exp_sat = 0;
    int   rnd_tab [8] = '{24, -24, 7, 8, -8, 0, 15, -9};
    int   sat_tab [8] = '{100000, -100000, 32767, -32768, 32768, -32769, 0, -1};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Round half toward +inf, divide by 2^s with floor, then clamp to the output range
    function automatic longint ref_q(input longint a, input int s, output bit clamped);
        longint p, v, r;
        p = longint'(1) << s;
        v = a + ((s > 0) ? p / 2 : 0);
        if (v >= 0) r = v / p;
        else r = -((-v + p - 1) / p);
        clamped = 0;
        if (r > 32767) begin r = 32767; clamped = 1; end
        if (r < -32768) begin r = -32768; clamped = 1; end
        return r;
    endfunction

    function automatic logic signed [31:0] gen(input int mode, input int row, input int i);
        if (mode == 1) return 32'(row * 10 + i);
        if (mode == 2 && row == 0) return 32'(rnd_tab[i]);
        if (mode == 3 && row == 0) return 32'(sat_tab[i]);
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return 32'($urandom_range(0, 131071)) - 32'd65536;
            default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    task automatic mon();
        bit           ev;
        logic [127:0] ed;
        int           er;
        ev = 0; ed = '0; er = 0;
        if (cyc == busy_from) exp_sat = 0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ev = 1; ed = q[0].data; er = q[0].row;
            if (q[0].sat) exp_sat = 1;
            void'(q.pop_front());
        end
        check("quant_valid", 128'(quant_valid), 128'(ev));
        check("quant_row", 128'(quant_row), 128'(er[5:0]));
        check("quantized_data", 128'(quantized_data), ed);
        check("busy", 128'(busy), 128'(cyc >= busy_from && cyc <= done_cyc));
        check("done", 128'(done), 128'(cyc == done_cyc));
        check("sat_flag", 128'(sat_flag), 128'(exp_sat));
    endtask

    task automatic next_cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_row();
        for (int i = 0; i < N; i++) acc_data[i*AW +: AW] = $urandom;
    endtask

    // gap: 0 none, 1 alternating, 2 random; rst_after>0 resets once that many rows are in
    task automatic do_run(input int s, input int mode, input int gap, input bit extras, input int rst_after);
        int            sent;
        bit            tog;
        exp_t          e;
        bit            cl;
        longint        r;
        logic [31:0]   lane;
        start = 1'b1; shift_amt = SW'(s);
        acc_valid = 1'($urandom_range(0, 1)); rand_row();
        busy_from = cyc + 1; done_cyc = BIG;
        next_cyc();
        start = 1'b0;
        sent = 0; tog = 1;
        while (sent < N) begin
            shift_amt = SW'($urandom);
            start = extras && (sent == 3);
            if (start) shift_amt = SW'(s + 7);
            case (gap)
                0: acc_valid = 1'b1;
                1: acc_valid = tog;
                default: acc_valid = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            e.cyc = cyc + 2; e.row = sent; e.data = '0; e.sat = 0;
            for (int i = 0; i < N; i++) begin
                lane = gen(mode, sent, i);
                acc_data[i*AW +: AW] = lane;
                r = ref_q(longint'($signed(lane)), s, cl);
                e.data[i*OW +: OW] = OW'(r);
                e.sat = e.sat | cl;
            end
            if (acc_valid) begin
                q.push_back(e);
                sent++;
                if (sent == N) done_cyc = cyc + 3;
            end
            next_cyc();
            if (rst_after > 0 && sent == rst_after) begin
                acc_valid = 1'b0; start = 1'b0; srst = 1'b1;
                next_cyc();
                srst = 1'b0;
                q.delete();
                exp_sat = 0; busy_from = BIG; done_cyc = BIG;
                return;
            end
        end
        start = 1'b0;
        if (extras) begin
            acc_valid = 1'b1; rand_row();
            next_cyc();
        end
        acc_valid = 1'b0;
        for (int k = 0; k < 40 && cyc <= done_cyc; k++) next_cyc();
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            acc_valid = 1'($urandom_range(0, 1)); rand_row();
            next_cyc();
        end
        acc_valid = 1'b0;
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; shift_amt = '0; acc_valid = 1'b0; acc_data = '0;
        @(posedge clk);
        #1;
        next_cyc();
        start = 1'b1; acc_valid = 1'b1; rand_row();
        next_cyc();
        srst = 1'b0; start = 1'b0; acc_valid = 1'b0;
        next_cyc();

        do_run(0, 1, 0, 0, -1);
        do_run(4, 2, 0, 0, -1);
        do_run(0, 3, 0, 0, -1);
        do_run(0, 1, 0, 0, -1);
        do_run(3, 0, 1, 1, -1);
        do_run(2, 0, 0, 0, 4);
        next_cyc();
        do_run(2, 1, 0, 0, -1);
        for (int k = 0; k < 10; k++)
            do_run(int'($urandom_range(0, 31)), 0, 2, 1'($urandom_range(0, 1)), -1);
        next_cyc();
        check("queue_drained", 128'(q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quantize_stage.md
Name: quantize_stage

Overview:
- Sits directly upstream of the SRAM write-out stage and produces its `quantized_data` row input.
- Takes one row of wide signed accumulator results per cycle from the systolic array and applies a programmable rounding arithmetic right-shift.
- Saturates each lane to OUTPUT_DATA_WIDTH.
- Emits exactly ARRAY_SIZE rows per run, each tagged with a row index, and signals completion with a one-cycle done pulse.

Parameters:
- ARRAY_SIZE, 8: lanes per row and rows per run.
- ACC_WIDTH, 32: signed accumulator width per lane.
- OUTPUT_DATA_WIDTH, 16: signed quantized width per lane.
- SHIFT_WIDTH, 5: width of the shift-amount field.

Ports:
- clk  input  1  clock; all logic on posedge.
- srst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a run; latches shift_amt.
- shift_amt  input  SHIFT_WIDTH  right-shift amount, 0..ACC_WIDTH-1.
- acc_valid  input  1  acc_data holds a valid row this cycle.
- acc_data  input  ARRAY_SIZE*ACC_WIDTH  signed lanes; lane i at [i*ACC_WIDTH +: ACC_WIDTH].
- quantized_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed lanes, same lane ordering.
- quant_valid  output  1  quantized_data and quant_row valid this cycle.
- quant_row  output  6  row index 0..ARRAY_SIZE-1 of the current output.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the last row exits.
- sat_flag  output  1  sticky; some lane saturated during the current run.

Behaviour:
- Reset (srst=1 at posedge) values:
  - all outputs 0; FSM=IDLE; row counter 0; pipeline valids 0; latched shift 0.
  - Applies mid-run: any in-flight rows are discarded and no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN; latch shift_amt; clear sat_flag; row counter=0.
  - acc_valid is ignored.
- RUN:
  - Each cycle with acc_valid=1 accepts a row into pipeline stage 1, tagged with the row counter, and increments the counter.
  - Acceptance of row ARRAY_SIZE-1 -> DRAIN.
  - acc_valid=0 cycles (gaps) are permitted and hold state.
- DRAIN:
  - acc_valid is ignored; no further rows are accepted.
  - When the last tagged row is presented with quant_valid=1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start while busy=1 is ignored; the latched shift is unchanged.
- start and srst in the same cycle: srst wins.
- busy=1 in RUN, DRAIN and DONE.
- Pipeline, 2 registered stages; latency from an accepted acc_valid to quant_valid is exactly 2 cycles; full throughput of 1 row/cycle.
- Stage 1, per lane:
  - Sign-extend acc to ACC_WIDTH+1 bits.
  - Add round constant 2^(shift-1) if shift>0, else 0.
  - Arithmetic shift right by shift (round-half-up toward +inf).
- Stage 2, per lane:
  - Saturate to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
  - Register the result.
  - Any lane clamped while the row is valid sets sat_flag, which holds until the next accepted start or srst.
- quantized_data is forced to 0 when quant_valid=0.
- quant_row is 0 when quant_valid=0.
- Row counter never exceeds ARRAY_SIZE-1; with ARRAY_SIZE rows/run there is no wrap. A new run restarts at 0.

Test Plan:
- Passthrough: start with shift_amt=0; 8 consecutive rows with lane i = row*10+i -> quant_valid on cycles start+3..start+10; quant_row 0..7; values identical; done pulse 1 cycle after row 7; sat_flag=0.
- Rounding: shift_amt=4; lanes {24, -24, 7, 8, -8, 0, 15, -9} -> {2, -1, 0, 1, 0, 0, 1, -1}.
- Saturation: shift_amt=0; lanes {100000, -100000, 32767, -32768, ...} -> {32767, -32768, 32767, -32768}; sat_flag=1 and stays 1 through done; the next start clears it.
- Gapped input with extras:
  - Input: acc_valid toggling 1,0,1,0; then a 9th acc_valid row supplied in DRAIN; start pulsed mid-RUN with a different shift_amt.
  - Required: exactly 8 outputs; the 9th row is dropped; the original shift is used throughout; done occurs once.
- Reset mid-run: srst asserted after row 3 is accepted -> next cycle all outputs 0, busy=0, no done. A fresh run then produces rows 0..7 correctly.
